// File: rtl/seg7_to_num_reader.sv
// Purpose: read back a multiplexed active-low 7-seg bus, debounce each digit, decode to value/dp/blank.
// Latency: STABLE_CNT qualifying samples to commit; outputs registered on the capturing edge.
// Backpressure: none; sample_en qualifies the bus, valid/err are single-cycle pulses.
// Optional: define SEG7_HEX_DECODE_EN to also decode A..F as 10..15.
module seg7_to_num_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sample_en,
  input  logic [6:0]                              seg7,
  input  logic                                    dpt,
  input  logic [DIGITS-1:0]                       com,
  output logic [4*DIGITS-1:0]                     num,
  output logic [DIGITS-1:0]                       dp,
  output logic [DIGITS-1:0]                       blank,
  output logic                                    valid,
  output logic                                    err,
  output logic [$clog2(DIGITS>1?DIGITS:2)-1:0]    upd_idx
);

  localparam int IW = $clog2(DIGITS > 1 ? DIGITS : 2);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CNT);

  // Pattern decoder: returns {recognised, blank, value}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {1'b1, 1'b0, 4'd0};
      7'b1111001: decode = {1'b1, 1'b0, 4'd1};
      7'b0100100: decode = {1'b1, 1'b0, 4'd2};
      7'b0110000: decode = {1'b1, 1'b0, 4'd3};
      7'b0011001: decode = {1'b1, 1'b0, 4'd4};
      7'b0010010: decode = {1'b1, 1'b0, 4'd5};
      7'b0000010: decode = {1'b1, 1'b0, 4'd6};
      7'b1111000: decode = {1'b1, 1'b0, 4'd7};
      7'b0000000: decode = {1'b1, 1'b0, 4'd8};
      7'b0010000: decode = {1'b1, 1'b0, 4'd9};
      7'b1111111: decode = {1'b1, 1'b1, 4'd0};
`ifdef SEG7_HEX_DECODE_EN
      7'b0001000: decode = {1'b1, 1'b0, 4'd10};
      7'b0000011: decode = {1'b1, 1'b0, 4'd11};
      7'b1000110: decode = {1'b1, 1'b0, 4'd12};
      7'b0100001: decode = {1'b1, 1'b0, 4'd13};
      7'b0000110: decode = {1'b1, 1'b0, 4'd14};
      7'b0001110: decode = {1'b1, 1'b0, 4'd15};
`endif
      default:    decode = {1'b0, 1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0]    cand [DIGITS];
  logic [CW-1:0] cnt  [DIGITS];

  logic [3:0]    nlow;
  logic [IW-1:0] sel;
  logic [7:0]    cur_cand;
  logic [CW-1:0] cur_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          match;
  logic          commit;
  logic          dec_ok;
  logic          dec_blank;
  logic [3:0]    dec_val;
  logic [3:0]    cur_num;
  logic          changed;

  // Count active (low) digit selects and find the selected digit index.
  always_comb begin
    nlow = '0;
    sel  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!com[i]) begin
        nlow = nlow + 1'b1;
        sel  = IW'(i);
      end
    end
  end

  // Run-length tracking, commit detection and decode for the selected digit.
  always_comb begin
    cur_cand = cand[sel];
    cur_cnt  = cnt[sel];
    match    = ({seg7, dpt} == cur_cand);
    nxt_cnt  = CW'(1);
    commit   = 1'b0;
    if (match) begin
      nxt_cnt = (cur_cnt == SAT) ? cur_cnt : cur_cnt + 1'b1;
      // A saturated run never re-commits; only the step onto SAT does.
      commit  = (cur_cnt == SAT - 1'b1);
    end else begin
      commit  = (SAT == CW'(1));
    end
    {dec_ok, dec_blank, dec_val} = decode(seg7);
    cur_num = num[{sel, 2'b00} +: 4];
    changed = (dec_val != cur_num) || (~dpt != dp[sel]) || (dec_blank != blank[sel]);
  end

  // Candidate/counter state, committed digits and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        cand[i] <= 8'hFF;
        cnt[i]  <= '0;
      end
      num     <= '0;
      dp      <= '0;
      blank   <= '1;
      valid   <= 1'b0;
      err     <= 1'b0;
      upd_idx <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (sample_en) begin
        if (nlow > 4'd1) begin
          // Several digits driven at once: flag it, leave all runs alone.
          err     <= 1'b1;
          upd_idx <= '0;
        end else if (nlow == 4'd1) begin
          cand[sel] <= {seg7, dpt};
          cnt[sel]  <= nxt_cnt;
          if (commit) begin
            if (!dec_ok) begin
              err     <= 1'b1;
              upd_idx <= sel;
            end else if (changed) begin
              num[{sel, 2'b00} +: 4] <= dec_val;
              dp[sel]                <= ~dpt;
              blank[sel]             <= dec_blank;
              valid                  <= 1'b1;
              upd_idx                <= sel;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_num_reader.sv
module tb_seg7_to_num_reader;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [6:0]  seg7;
  logic        dpt;
  logic [3:0]  com;
  logic [15:0] num;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        valid;
  logic        err;
  logic [1:0]  upd_idx;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_to_num_reader #(.DIGITS(4), .STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .seg7(seg7), .dpt(dpt),
    .com(com), .num(num), .dp(dp), .blank(blank), .valid(valid), .err(err),
    .upd_idx(upd_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus values; returns 1 time unit after the capturing edge.
  task automatic step(input logic en, input logic [3:0] c, input logic [6:0] s, input logic d);
    @(negedge clk);
    sample_en = en;
    com       = c;
    seg7      = s;
    dpt       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_num"}, 32'(num), 32'h0000);
    chk({tag, "_dp"}, 32'(dp), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'hF);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_idx"}, 32'(upd_idx), 32'h0);
  endtask

  logic [15:0] exp_num_d1;
  logic [3:0]  exp_blank_d1;
  logic        exp_valid_d1;
  logic        exp_err_d1;

  initial begin
`ifdef SEG7_HEX_DECODE_EN
    exp_num_d1   = 16'h0A02;
    exp_blank_d1 = 4'b1000;
    exp_valid_d1 = 1'b1;
    exp_err_d1   = 1'b0;
`else
    exp_num_d1   = 16'h0802;
    exp_blank_d1 = 4'b1010;
    exp_valid_d1 = 1'b0;
    exp_err_d1   = 1'b1;
`endif
    rst_n = 1'b0; sample_en = 1'b0; com = 4'hF; seg7 = 7'h7F; dpt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Digit 0 shows "2"; a gap with sample_en low must not break the run.
    step(1, 4'b1110, 7'b0100100, 1);
    step(1, 4'b1110, 7'b0100100, 1);
    step(0, 4'b1110, 7'b1000000, 0);
    step(1, 4'b1110, 7'b0100100, 1);
    chk("d0_s3_novalid", 32'(valid), 32'h0);
    step(1, 4'b1110, 7'b0100100, 1);
    chk("d0_valid", 32'(valid), 32'h1);
    chk("d0_idx", 32'(upd_idx), 32'h0);
    chk("d0_num", 32'(num), 32'h0002);
    chk("d0_blank", 32'(blank), 32'hE);
    chk("d0_err", 32'(err), 32'h0);
    step(1, 4'b1110, 7'b0100100, 1);
    chk("d0_s5_nopulse", 32'({valid, err}), 32'h0);
    step(1, 4'b1110, 7'b0100100, 1);
    chk("d0_s6_nopulse", 32'({valid, err}), 32'h0);

    // Digit 2: run of "3" interrupted, then "8"; digit-0 samples interleaved.
    step(1, 4'b1011, 7'b0110000, 1);
    step(1, 4'b1011, 7'b0110000, 1);
    step(1, 4'b1011, 7'b0110000, 1);
    step(1, 4'b1011, 7'b0000000, 1);
    step(1, 4'b1110, 7'b0100100, 1);
    step(1, 4'b1011, 7'b0000000, 1);
    step(1, 4'b1011, 7'b0000000, 1);
    chk("d2_s3_novalid", 32'(valid), 32'h0);
    step(1, 4'b1011, 7'b0000000, 1);
    chk("d2_valid", 32'(valid), 32'h1);
    chk("d2_idx", 32'(upd_idx), 32'h2);
    chk("d2_num", 32'(num), 32'h0802);

    // Digit 1: hex "A" pattern.
    repeat (4) step(1, 4'b1101, 7'b0001000, 1);
    chk("d1_valid", 32'(valid), 32'(exp_valid_d1));
    chk("d1_err", 32'(err), 32'(exp_err_d1));
    chk("d1_idx", 32'(upd_idx), 32'h1);
    chk("d1_num", 32'(num), 32'(exp_num_d1));

    // Illegal / idle digit selects.
    step(1, 4'b1100, 7'b1000000, 1);
    chk("com2_err", 32'(err), 32'h1);
    chk("com2_valid", 32'(valid), 32'h0);
    chk("com2_idx", 32'(upd_idx), 32'h0);
    chk("com2_num", 32'(num), 32'(exp_num_d1));
    step(1, 4'b1111, 7'b1000000, 1);
    chk("comnone_nopulse", 32'({valid, err}), 32'h0);

    // Digit 0 re-commits the same value after a short detour: no pulse.
    step(1, 4'b1110, 7'b1111001, 1);
    step(1, 4'b1110, 7'b1111001, 1);
    repeat (4) step(1, 4'b1110, 7'b0100100, 1);
    chk("d0_same_nopulse", 32'({valid, err}), 32'h0);

    // Digit 3 shows "1." with decimal point lit.
    repeat (4) step(1, 4'b0111, 7'b1111001, 0);
    chk("d3_valid", 32'(valid), 32'h1);
    chk("d3_idx", 32'(upd_idx), 32'h3);
    chk("d3_num", 32'(num), 32'(exp_num_d1 | 16'h1000));
    chk("d3_dp", 32'(dp), 32'h8);
    chk("d3_blank", 32'(blank), 32'(exp_blank_d1 & 4'b0111));

    // Partial run then asynchronous reset between clock edges.
    step(1, 4'b0111, 7'b0000010, 1);
    step(1, 4'b0111, 7'b0000010, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // The lost partial run must restart from one.
    step(1, 4'b0111, 7'b0000010, 1);
    step(1, 4'b0111, 7'b0000010, 1);
    chk("arst_runlost", 32'({valid, err}), 32'h0);
    chk("arst_num", 32'(num), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_to_num_reader.md
# seg7_to_num_reader

Reads back a multiplexed, active-low seven-segment display bus and recovers the digit values being shown; it is the reverse of the team's number-to-seg7 decoders. It sits beside the display driver (self-check / loopback) or on a captured external display bus, filters each digit's pattern for stability over several samples, decodes it to a 4-bit value plus decimal point, and reports each change with a one-cycle valid pulse.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CNT, 4: consecutive identical samples required before a digit is committed (1..15).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sample_en  input  1  sample strobe; bus inputs are ignored when low.
- seg7  input  7  segment pattern, gfedcba, active-low (0 = lit).
- dpt  input  1  decimal point, active-low.
- com  input  DIGITS  digit select, active-low one-hot.
- num  output  4*DIGITS  committed value per digit; digit i at [4i+3:4i].
- dp  output  DIGITS  committed decimal point per digit, active-high (1 = lit).
- blank  output  DIGITS  1 = digit committed as all segments off.
- valid  output  1  one-cycle pulse: a digit's committed value changed.
- err  output  1  one-cycle pulse: unrecognised stable pattern or illegal com.
- upd_idx  output  clog2(DIGITS) (min 1)  digit index for the current valid/err pulse.

## Operation
- Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111; anything else unrecognised.
- Per digit i: candidate register {seg7,dpt} and saturating match counter (width clog2(STABLE_CNT+1)).
- Sample = clk edge with sample_en=1. If com has exactly one bit low (digit i):
  - {seg7,dpt} equals candidate i: counter increments, saturates at STABLE_CNT.
  - Else: candidate i loaded, counter = 1.
  - Commit event when counter reaches STABLE_CNT on this sample (STABLE_CNT=1: every candidate load).
- Commit, recognised pattern: if decoded {num,dp,blank} differs from stored digit i, update stored digit i, pulse valid, upd_idx=i; identical result: no pulse. Blank commits blank=1, num=0.
- Commit, unrecognised: stored digit i unchanged, err pulse, upd_idx=i.
- Sample with com all-high: ignored, no pulse. com with two or more bits low: ignored, err pulse, upd_idx=0; counters untouched.
- Saturated counter holding a stable pattern produces no further pulses.
- valid and err never high together.

## Timing
- Reset values: num=0, dp=0, blank=all 1s, valid=0, err=0, upd_idx=0; candidates=1111111/1, counters=0.
- Outputs registered: results appear on the same edge that captures the qualifying sample (visible the following cycle); valid/err high exactly one cycle.
- Minimum latency from a new stable pattern to valid: STABLE_CNT samples.
- sample_en low: all state holds; intervening cycles don't break a match run.
- Samples of other digits don't reset digit i's run.
- rst_n low mid-run: immediate clear to reset values; a partial run is lost.

## Configuration
- SEG7_HEX_DECODE_EN defined: also decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 to values 10..15.
- Undefined: those six patterns are unrecognised (err on commit); only 0-9 and blank decode.

## Test plan
- Reset, DIGITS=4, STABLE_CNT=4: all outputs at reset values; blank=4'b1111.
- Digit 0 (com=1110) seg7=0100100, dpt=1, four samples -> valid pulse after 4th, upd_idx=0, num[3:0]=2, blank[0]=0; 5th and 6th identical samples -> no pulse.
- Digit 2 shows 0110000 ×3 then 0000000 ×1 then 0000000 ×3 -> no pulse until 4th 0000000 sample; num[11:8]=8.
- Digit 1 seg7=0001000 ×4: without SEG7_HEX_DECODE_EN -> err, upd_idx=1, num[7:4] unchanged; with it -> valid, num[7:4]=4'hA.
- com=1100 with sample_en=1 -> err, upd_idx=0, no state change; com=1111 -> no pulse.
- Digit 3 with dpt=0 and seg7=1111001 ×4 -> valid, num[15:12]=1, dp[3]=1; rst_n low after 2 further differing samples -> all outputs back to reset values asynchronously.
